// File: rtl/ssemi_decimator_config_regfile.sv
// ---------------------------------------------------------------------------
// ssemi_decimator_config_regfile
//
// Purpose:
//   Responder end of the decimator configuration bus. Writes land in shadow
//   FIR / halfband coefficient banks, the decimation-factor register or the
//   scratch address. A CTRL commit copies the shadow banks into the active
//   banks (one index per cycle) that feed the FIR and halfband stages.
//   Illegal addresses or data drop the write and raise a sticky error whose
//   type is the code of the first error since the last clear.
//
// Ports:
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_config_valid      write request
//   i_config_addr[8]    write address
//   i_config_data[32]   write data
//   o_config_ready      responder can accept a write (IDLE only)
//   i_fir_rd_idx        active FIR bank read index
//   o_fir_coeff         active FIR coefficient, 1-cycle latency
//   i_hb_rd_idx         active halfband bank read index
//   o_hb_coeff          active halfband coefficient, 1-cycle latency
//   o_decim_factor[16]  current decimation factor
//   o_commit_busy       commit copy in progress
//   o_commit_done       one-cycle pulse at the end of a commit
//   o_error             sticky error flag
//   o_error_type[3]     code of the first error since the last clear
// ---------------------------------------------------------------------------
module ssemi_decimator_config_regfile #(
    parameter int FIR_TAPS      = 64,
    parameter int HALFBAND_TAPS = 31,
    parameter int HB_BASE       = 64,
    parameter int FIR_COEFF_W   = 18,
    parameter int HB_COEFF_W    = 18,
    parameter int DEFAULT_DECIM = 16,
    localparam int FIR_IDX_W    = $clog2(FIR_TAPS),
    localparam int HB_IDX_W     = $clog2(HALFBAND_TAPS)
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_config_valid,
    input  logic [7:0]                    i_config_addr,
    input  logic [31:0]                   i_config_data,
    output logic                          o_config_ready,
    input  logic [FIR_IDX_W-1:0]          i_fir_rd_idx,
    output logic signed [FIR_COEFF_W-1:0] o_fir_coeff,
    input  logic [HB_IDX_W-1:0]           i_hb_rd_idx,
    output logic signed [HB_COEFF_W-1:0]  o_hb_coeff,
    output logic [15:0]                   o_decim_factor,
    output logic                          o_commit_busy,
    output logic                          o_commit_done,
    output logic                          o_error,
    output logic [2:0]                    o_error_type
);

    // Active banks are padded to a power of two; the padding entries are
    // never written, so an out-of-range read index naturally returns 0.
    localparam int FIR_DEPTH = 1 << FIR_IDX_W;
    localparam int HB_DEPTH  = 1 << HB_IDX_W;
    localparam int N_COMMIT  = (FIR_TAPS > HALFBAND_TAPS) ? FIR_TAPS : HALFBAND_TAPS;
    localparam int K_W       = (N_COMMIT > 1) ? $clog2(N_COMMIT) : 1;
    localparam int HB_CENTRE = (HALFBAND_TAPS - 1) / 2;

    localparam logic [7:0] ADDR_CTRL  = 8'hF0;
    localparam logic [7:0] ADDR_DECIM = 8'hF1;
    localparam logic [7:0] ADDR_SCR   = 8'hFF;

    typedef enum logic [1:0] {S_IDLE, S_COMMIT, S_DONE} state_t;

    state_t                         r_state;
    state_t                         w_next;
    logic [K_W-1:0]                 r_k;
    logic signed [FIR_COEFF_W-1:0]  r_fir_shd [0:FIR_DEPTH-1];
    logic signed [FIR_COEFF_W-1:0]  r_fir_act [0:FIR_DEPTH-1];
    logic signed [HB_COEFF_W-1:0]   r_hb_shd  [0:HB_DEPTH-1];
    logic signed [HB_COEFF_W-1:0]   r_hb_act  [0:HB_DEPTH-1];
    logic [15:0]                    r_decim;
    logic                           r_error;
    logic [2:0]                     r_error_type;

    logic [31:0] w_addr32;
    logic [31:0] w_hb_loc;
    logic        w_accept, w_in_fir, w_in_hb, w_is_ctrl, w_is_decim, w_is_scr;
    logic        w_fir_rng_ok, w_hb_rng_ok;
    logic        w_err;
    logic [2:0]  w_err_code;
    logic        w_wr_ok, w_commit_req, w_clear_req;
    logic [31:FIR_COEFF_W-1] w_fir_hi;
    logic [31:HB_COEFF_W-1]  w_hb_hi;

    // ---------------- address decode and data checks ----------------
    assign w_addr32   = {24'd0, i_config_addr};
    assign w_hb_loc   = w_addr32 - HB_BASE;
    assign w_accept   = i_config_valid && o_config_ready;
    assign w_in_fir   = (w_addr32 < FIR_TAPS);
    assign w_in_hb    = (w_addr32 >= HB_BASE) && (w_addr32 < HB_BASE + HALFBAND_TAPS);
    assign w_is_ctrl  = (i_config_addr == ADDR_CTRL);
    assign w_is_decim = (i_config_addr == ADDR_DECIM);
    assign w_is_scr   = (i_config_addr == ADDR_SCR);

    // A coefficient fits when every bit above the sign bit copies the sign.
    assign w_fir_hi     = i_config_data[31:FIR_COEFF_W-1];
    assign w_hb_hi      = i_config_data[31:HB_COEFF_W-1];
    assign w_fir_rng_ok = (&w_fir_hi) || ~(|w_fir_hi);
    assign w_hb_rng_ok  = (&w_hb_hi) || ~(|w_hb_hi);

    always_comb begin
        w_err      = 1'b0;
        w_err_code = 3'b000;
        if (w_in_fir) begin
            if (!w_fir_rng_ok) begin
                w_err      = 1'b1;
                w_err_code = 3'b101;
            end
        end else if (w_in_hb) begin
            if (!w_hb_rng_ok) begin
                w_err      = 1'b1;
                w_err_code = 3'b101;
            end else if (w_hb_loc[0] && (w_hb_loc != HB_CENTRE) && (i_config_data != 32'd0)) begin
                // Halfband odd taps are structurally zero except the centre.
                w_err      = 1'b1;
                w_err_code = 3'b100;
            end
        end else if (w_is_decim) begin
            if (i_config_data[15:0] < 16'd2) begin
                w_err      = 1'b1;
                w_err_code = 3'b110;
            end
        end else if (!w_is_ctrl && !w_is_scr) begin
            w_err      = 1'b1;
            w_err_code = 3'b011;
        end
    end

    assign w_wr_ok      = w_accept && !w_err;
    assign w_commit_req = w_accept && w_is_ctrl && i_config_data[0];
    assign w_clear_req  = w_accept && w_is_ctrl && i_config_data[1];

    // ---------------- FSM: state register ----------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_k     <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_COMMIT) r_k <= r_k + 1'b1;
            else                     r_k <= '0;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (w_commit_req) w_next = S_COMMIT;
            S_COMMIT: if (r_k == K_W'(N_COMMIT - 1)) w_next = S_DONE;
            S_DONE:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        o_config_ready = (r_state == S_IDLE);
        o_commit_busy  = (r_state == S_COMMIT);
        o_commit_done  = (r_state == S_DONE);
    end

    // ---------------- register file and commit copy ----------------
    // SCRATCH (0xFF) has no read path on this bus, so its write is accepted
    // and has no observable state to hold.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < FIR_DEPTH; i++) begin
                r_fir_shd[i] <= '0;
                r_fir_act[i] <= '0;
            end
            for (int i = 0; i < HB_DEPTH; i++) begin
                r_hb_shd[i] <= '0;
                r_hb_act[i] <= '0;
            end
            r_decim      <= 16'(DEFAULT_DECIM);
            r_error      <= 1'b0;
            r_error_type <= 3'b000;
        end else begin
            for (int i = 0; i < FIR_TAPS; i++) begin
                if (w_wr_ok && w_in_fir && (w_addr32 == i))
                    r_fir_shd[i] <= i_config_data[FIR_COEFF_W-1:0];
                if ((r_state == S_COMMIT) && (r_k == K_W'(i)))
                    r_fir_act[i] <= r_fir_shd[i];
            end
            for (int i = 0; i < HALFBAND_TAPS; i++) begin
                if (w_wr_ok && w_in_hb && (w_addr32 == HB_BASE + i))
                    r_hb_shd[i] <= i_config_data[HB_COEFF_W-1:0];
                if ((r_state == S_COMMIT) && (r_k == K_W'(i)))
                    r_hb_act[i] <= r_hb_shd[i];
            end
            if (w_wr_ok && w_is_decim)
                r_decim <= i_config_data[15:0];
            // CTRL never errors, so clear and set cannot collide.
            if (w_clear_req) begin
                r_error      <= 1'b0;
                r_error_type <= 3'b000;
            end else if (w_accept && w_err) begin
                r_error <= 1'b1;
                if (!r_error) r_error_type <= w_err_code;
            end
        end
    end

    // ---------------- registered read ports ----------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_fir_coeff <= '0;
            o_hb_coeff  <= '0;
        end else begin
            o_fir_coeff <= r_fir_act[i_fir_rd_idx];
            o_hb_coeff  <= r_hb_act[i_hb_rd_idx];
        end
    end

    assign o_decim_factor = r_decim;
    assign o_error        = r_error;
    assign o_error_type   = r_error_type;

endmodule
